// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the load hazard / stall unit.
//   hz_state_t : controller state (RUN, LOAD_STALL, FREEZE)
//   sb_entry_t : one scoreboard slot {valid, rd}
//   REG_ZERO   : register index that never carries a real dependency
// Scoreboard rd fields are SB_RD_W bits wide; register indices of up to
// SB_RD_W bits are zero-extended into them.
package hazard_pkg;

  localparam int SB_RD_W = 8;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FREEZE     = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
  } sb_entry_t;

  localparam logic [SB_RD_W-1:0] REG_ZERO = 8'd0;

endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: age-ordered shift register of in-flight load destinations
// plus the match logic against the source registers of the ID instruction.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears all slots)
//   shift_en          advance one slot (low while the pipeline is frozen)
//   push, push_rd     slot 0 receives {1, push_rd} on a shift when push=1
//   rs, rt            source registers of the ID instruction
//   use_rs, use_rt    ID instruction actually reads rs / rt
//   hit               some valid, non-zero entry matches a used source
import hazard_pkg::*;

module load_scoreboard #(
  parameter int LOAD_LATENCY = 1,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             push,
  input  logic [REG_W-1:0] push_rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             use_rs,
  input  logic             use_rt,
  output logic             hit
);

  sb_entry_t                 sb_r    [LOAD_LATENCY];
  logic [LOAD_LATENCY-1:0]   match_s;
  logic [SB_RD_W-1:0]        rs_ext_s;
  logic [SB_RD_W-1:0]        rt_ext_s;
  logic [SB_RD_W-1:0]        push_ext_s;

  assign rs_ext_s   = SB_RD_W'(rs);
  assign rt_ext_s   = SB_RD_W'(rt);
  assign push_ext_s = SB_RD_W'(push_rd);

  // Shift register: slot 0 takes the issuing load (or a bubble), oldest slot falls off.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        sb_r[i] <= '{valid: 1'b0, rd: REG_ZERO};
      end
    end else if (shift_en) begin
      if (push) begin
        sb_r[0] <= '{valid: 1'b1, rd: push_ext_s};
      end else begin
        sb_r[0] <= '{valid: 1'b0, rd: REG_ZERO};
      end
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        sb_r[i] <= sb_r[i-1];
      end
    end
  end

  // Per-slot match; a destination of register zero never creates a dependency.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < LOAD_LATENCY; i++) begin
      match_s[i] = sb_r[i].valid && (sb_r[i].rd != REG_ZERO) &&
                   ((use_rs && (sb_r[i].rd == rs_ext_s)) ||
                    (use_rt && (sb_r[i].rd == rt_ext_s)));
    end
  end

  assign hit = |match_s;

endmodule

// File: rtl/load_hazard_stall_unit.sv
// load_hazard_stall_unit: stall / flush / freeze controller for the 5-stage
// pipeline. Resolves load-use hazards (stall PC and IF/ID, bubble ID/EX),
// taken branches resolved in ID (flush IF/ID) and data-memory wait (freeze).
// Outputs respond combinationally in the same cycle; state_o is debug only.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_id_rs/rt, if_id_use_rs/rt  sources of the ID instruction
//   id_is_load, id_load_rd        ID instruction is a load, and its target
//   branch_taken                  branch in ID resolved taken
//   mem_stall                     data memory busy, freeze everything
//   pc_write, if_id_write         PC / IF/ID enables
//   id_ex_write, id_ex_flush      ID/EX enable / bubble insert
//   if_id_flush                   clear IF/ID
//   state_o                       current controller state
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cnt,
// flush_cnt and freeze_cnt outputs (cleared by rst).
import hazard_pkg::*;

module load_hazard_stall_unit #(
  parameter int LOAD_LATENCY = 1,
  parameter int REG_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_use_rs,
  input  logic             if_id_use_rt,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] id_load_rd,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             if_id_flush,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic [31:0]      freeze_cnt
`endif
);

  hz_state_t state_r;
  logic      hit_s;
  logic      push_s;
  logic      shift_en_s;

  // The ID instruction issues only when it is neither stalled nor frozen.
  assign shift_en_s = !mem_stall;
  assign push_s     = id_is_load && !hit_s && !mem_stall && !rst;

  load_scoreboard #(
    .LOAD_LATENCY (LOAD_LATENCY),
    .REG_W        (REG_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en_s),
    .push     (push_s),
    .push_rd  (id_load_rd),
    .rs       (if_id_rs),
    .rt       (if_id_rt),
    .use_rs   (if_id_use_rs),
    .use_rt   (if_id_use_rt),
    .hit      (hit_s)
  );

  // Controller state tracking which condition currently owns the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_stall)  state_r <= FREEZE;
          else if (hit_s) state_r <= LOAD_STALL;
          else            state_r <= RUN;
        end
        LOAD_STALL: begin
          if (mem_stall)   state_r <= FREEZE;
          else if (!hit_s) state_r <= RUN;
          else             state_r <= LOAD_STALL;
        end
        FREEZE: begin
          if (mem_stall)  state_r <= FREEZE;
          else if (hit_s) state_r <= LOAD_STALL;
          else            state_r <= RUN;
        end
        default: state_r <= RUN;
      endcase
    end
  end

  assign state_o = state_r;

  // Same-cycle pipeline control; priority reset > freeze > stall > branch.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    id_ex_flush = 1'b0;
    if_id_flush = 1'b0;
    if (rst) begin
      // Drain: hold fetch, bubble ID/EX, clear IF/ID.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if_id_flush = 1'b1;
    end else if (mem_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (hit_s) begin
      // Stall wins over a branch: ID holds and the branch re-resolves next cycle.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else begin
      if_id_flush = branch_taken;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_ev_s;
  logic flush_ev_s;
  logic freeze_ev_s;

  assign freeze_ev_s = !rst && mem_stall;
  assign stall_ev_s  = !rst && !mem_stall && hit_s;
  assign flush_ev_s  = !rst && !mem_stall && !hit_s && branch_taken;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      flush_cnt  <= 32'd0;
      freeze_cnt <= 32'd0;
    end else begin
      if (stall_ev_s && (stall_cnt != 32'hFFFF_FFFF))   stall_cnt  <= stall_cnt + 32'd1;
      if (flush_ev_s && (flush_cnt != 32'hFFFF_FFFF))   flush_cnt  <= flush_cnt + 32'd1;
      if (freeze_ev_s && (freeze_cnt != 32'hFFFF_FFFF)) freeze_cnt <= freeze_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_hazard_stall_unit.sv
// Bench for load_hazard_stall_unit: two instances (LOAD_LATENCY 1 and 2)
// share one stimulus stream. A reference model tracks pending loads as
// {rd, cycles-left} records; expected outputs are queued when inputs are
// driven and compared against the DUT at the following falling edge.
module tb_load_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] if_id_rs, if_id_rt, id_load_rd;
  logic       if_id_use_rs, if_id_use_rt, id_is_load, branch_taken, mem_stall;

  logic       pc_write_a, if_id_write_a, id_ex_write_a, id_ex_flush_a, if_id_flush_a;
  logic       pc_write_b, if_id_write_b, id_ex_write_b, id_ex_flush_b, if_id_flush_b;
  logic [1:0] state_a, state_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_a, flush_cnt_a, freeze_cnt_a;
  logic [31:0] stall_cnt_b, flush_cnt_b, freeze_cnt_b;
`endif

  logic [6:0] obs [2];
  assign obs[0] = {pc_write_a, if_id_write_a, id_ex_write_a, id_ex_flush_a, if_id_flush_a, state_a};
  assign obs[1] = {pc_write_b, if_id_write_b, id_ex_write_b, id_ex_flush_b, if_id_flush_b, state_b};

  always #5 clk = ~clk;

  load_hazard_stall_unit #(.LOAD_LATENCY(1), .REG_W(5)) u_dut_l1 (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .id_is_load(id_is_load), .id_load_rd(id_load_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .id_ex_write(id_ex_write_a),
    .id_ex_flush(id_ex_flush_a), .if_id_flush(if_id_flush_a), .state_o(state_a)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a), .freeze_cnt(freeze_cnt_a)
`endif
  );

  load_hazard_stall_unit #(.LOAD_LATENCY(2), .REG_W(5)) u_dut_l2 (
    .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_use_rs(if_id_use_rs), .if_id_use_rt(if_id_use_rt),
    .id_is_load(id_is_load), .id_load_rd(id_load_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .id_ex_write(id_ex_write_b),
    .id_ex_flush(id_ex_flush_b), .if_id_flush(if_id_flush_b), .state_o(state_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b), .freeze_cnt(freeze_cnt_b)
`endif
  );

  typedef struct {
    int         dut;
    logic [6:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   check_cnt = 0;
  int   fail_cnt  = 0;

  // Reference model: pending loads per instance, and modelled state.
  int pend_rd   [2][4];
  int pend_left [2][4];
  int model_st  [2];

  task automatic check_eq(input string tag, input logic [6:0] act, input logic [6:0] exp);
    check_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual={pc,ifw,exw,exfl,iffl,st}=%b required=%b", tag, act, exp);
    end
  endtask

  function automatic bit model_hazard(input int k, input int rs, input int rt,
                                      input bit urs, input bit urt);
    for (int j = 0; j < 4; j++) begin
      if (pend_left[k][j] > 0 && pend_rd[k][j] != 0 &&
          ((urs && pend_rd[k][j] == rs) || (urt && pend_rd[k][j] == rt)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      model_st[k] = 0;
      for (int j = 0; j < 4; j++) begin
        pend_rd[k][j]   = 0;
        pend_left[k][j] = 0;
      end
    end
  endtask

  task automatic step(input string tag, input int rs, input int rt, input bit urs,
                      input bit urt, input bit ld, input int lrd, input bit br,
                      input bit ms, input bit r);
    exp_t       e;
    bit         hz;
    logic [1:0] st;
    @(posedge clk);
    #1;
    rst = r; if_id_rs = 5'(rs); if_id_rt = 5'(rt);
    if_id_use_rs = urs; if_id_use_rt = urt;
    id_is_load = ld; id_load_rd = 5'(lrd);
    branch_taken = br; mem_stall = ms;
    for (int k = 0; k < 2; k++) begin
      hz = model_hazard(k, rs, rt, urs, urt);
      st = 2'(model_st[k]);
      if (r)       e.v = {5'b00111, st};
      else if (ms) e.v = {5'b00000, st};
      else if (hz) e.v = {5'b00110, st};
      else         e.v = {4'b1110, br, st};
      e.dut = k;
      e.tag = tag;
      exp_q.push_back(e);
      // Advance model for the coming clock edge.
      model_st[k] = r ? 0 : (ms ? 2 : (hz ? 1 : 0));
      if (r) begin
        for (int j = 0; j < 4; j++) pend_left[k][j] = 0;
      end else if (!ms) begin
        for (int j = 0; j < 4; j++)
          if (pend_left[k][j] > 0) pend_left[k][j]--;
        if (ld && !hz) begin
          for (int j = 0; j < 4; j++) begin
            if (pend_left[k][j] == 0) begin
              pend_rd[k][j]   = lrd;
              pend_left[k][j] = k + 1;
              break;
            end
          end
        end
      end
    end
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq($sformatf("%s/L%0d", e.tag, e.dut + 1), obs[e.dut], e.v);
    end
  endtask

  // Convenience wrappers for common instruction shapes.
  task automatic nop(input string tag);
    step(tag, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input string tag, input int rd);
    step(tag, 1, 0, 1'b1, 1'b0, 1'b1, rd, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic use_rs(input string tag, input int rs, input bit br, input bit ms, input bit r);
    step(tag, rs, 30, 1'b1, 1'b0, 1'b0, 0, br, ms, r);
  endtask

  initial begin
    rst = 1'b1; if_id_rs = 5'd0; if_id_rt = 5'd0; if_id_use_rs = 1'b0;
    if_id_use_rt = 1'b0; id_is_load = 1'b0; id_load_rd = 5'd0;
    branch_taken = 1'b0; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    model_clear();

    step("reset", 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    nop("first_run");
    nop("idle");

    // lw $5 then immediate user held in ID.
    lw("lw5", 5);
    use_rs("use5_a", 5, 1'b0, 1'b0, 1'b0);
    use_rs("use5_b", 5, 1'b0, 1'b0, 1'b0);
    use_rs("use5_c", 5, 1'b0, 1'b0, 1'b0);
    nop("idle2");

    // $0 destination never matches.
    lw("lw0", 0);
    use_rs("use0", 0, 1'b0, 1'b0, 1'b0);
    nop("idle3");

    // lw $7, independent, then user of $7 via rt.
    lw("lw7", 7);
    nop("indep");
    step("use7_rt_a", 2, 7, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step("use7_rt_b", 2, 7, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    nop("idle4");

    // Hazard and taken branch together; stall wins.
    lw("lw9", 9);
    use_rs("br9_a", 9, 1'b1, 1'b0, 1'b0);
    use_rs("br9_b", 9, 1'b1, 1'b0, 1'b0);
    use_rs("br9_c", 9, 1'b1, 1'b0, 1'b0);
    nop("idle5");

    // Freeze during a load stall; remaining bubbles still occur.
    lw("lw3", 3);
    use_rs("st3", 3, 1'b0, 1'b0, 1'b0);
    use_rs("frz3_a", 3, 1'b0, 1'b1, 1'b0);
    use_rs("frz3_b", 3, 1'b0, 1'b1, 1'b0);
    use_rs("frz3_c", 3, 1'b0, 1'b1, 1'b0);
    use_rs("rel3_a", 3, 1'b0, 1'b0, 1'b0);
    use_rs("rel3_b", 3, 1'b0, 1'b0, 1'b0);
    nop("idle6");

    // Back-to-back loads.
    lw("lw11", 11);
    lw("lw12", 12);
    use_rs("use11", 11, 1'b0, 1'b0, 1'b0);
    use_rs("use12", 12, 1'b0, 1'b0, 1'b0);
    use_rs("use12_b", 12, 1'b0, 1'b0, 1'b0);

    // Reset during a load stall clears the pending load.
    lw("lw4", 4);
    use_rs("st4", 4, 1'b0, 1'b0, 1'b0);
    use_rs("rst4", 4, 1'b0, 1'b0, 1'b1);
    use_rs("post_rst4", 4, 1'b0, 1'b0, 1'b0);

    // Random mix.
    for (int i = 0; i < 60; i++) begin
      step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/load_hazard_stall_unit.md
Name: load_hazard_stall_unit

Overview:
- Producer-side hazard controller for the 5-stage MIPS pipeline; the counterpart of forwarding.
- Forwarding resolves hazards by steering operands. This block resolves what forwarding cannot:
  - load-use dependencies, by stalling PC/IF-ID and injecting ID/EX bubbles;
  - taken branches resolved in ID, by flushing IF/ID;
  - data-memory wait, by freezing the whole pipeline.
- Holds a small scoreboard of in-flight load destinations.

Parameters:
- LOAD_LATENCY, 1, number of cycles after a load leaves ID during which a dependent ID instruction cannot be served by forwarding (range 1..4).
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- if_id_rs  in  REG_W  source 1 of the instruction in ID.
- if_id_rt  in  REG_W  source 2 of the instruction in ID.
- if_id_use_rs  in  1  ID instruction reads rs.
- if_id_use_rt  in  1  ID instruction reads rt.
- id_is_load  in  1  ID instruction is a load (memRead).
- id_load_rd  in  REG_W  destination of that load.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- mem_stall  in  1  data memory not ready; freeze all stages.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX enable (0 only during freeze).
- id_ex_flush  out  1  load a bubble (control=0) into ID/EX.
- if_id_flush  out  1  clear IF/ID.
- state_o  out  2  current state (debug).

Behaviour:
- Reset is synchronous and active-high; the clock is clk and the reset is rst.
- While rst=1: scoreboard cleared, state=RUN.
  - Outputs: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1, if_id_flush=1 (pipeline drains).
- First cycle after reset with no hazard: pc_write=1, if_id_write=1, id_ex_write=1, flushes=0.
- Scoreboard: LOAD_LATENCY entries {valid, rd}, age-ordered shift register.
  - Advances one slot per non-frozen cycle. The oldest entry is dropped.
  - Slot 0 is loaded with {1, id_load_rd} when id_is_load and the ID instruction actually issues (no stall, no freeze, no flush); otherwise slot 0 gets {0, x}.
  - An entry with rd=0 never matches.
- hazard = any valid entry with rd==if_id_rs && if_id_use_rs, or rd==if_id_rt && if_id_use_rt. Combinational from the scoreboard and current ID fields.
- States: RUN, LOAD_STALL, FREEZE.
  - RUN:
    - mem_stall → FREEZE.
    - Else if hazard → LOAD_STALL.
  - LOAD_STALL:
    - mem_stall → FREEZE.
    - Else if !hazard → RUN.
    - Stays in LOAD_STALL while the hazard persists.
  - FREEZE:
    - !mem_stall → RUN, or LOAD_STALL if hazard.
- Outputs are combinational from inputs and current scoreboard (same-cycle response).
  - Freeze (mem_stall=1, highest priority): pc_write=0, if_id_write=0, id_ex_write=0, no flushes; scoreboard holds.
  - Stall (hazard, no freeze): pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
  - Branch (branch_taken, no hazard, no freeze): if_id_flush=1, pc_write=1.
  - Stall overrides branch. ID holds, so branch_taken re-evaluates with correct operands next cycle.
- Latency: LOAD_LATENCY=1 gives exactly one bubble for an immediately dependent instruction. In general, max bubbles = LOAD_LATENCY − distance + 1.
- Back-to-back loads fill consecutive slots; no overflow is possible, since depth equals latency.
- Reset mid-stall or mid-freeze clears everything; no pending stall survives.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[31:0], flush_cnt[31:0] and freeze_cnt[31:0].
  - Each increments once per cycle in which its condition drives the outputs.
  - Each saturates at 0xFFFFFFFF and is cleared by rst.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - hz_state_t enum (RUN=2'd0, LOAD_STALL=2'd1, FREEZE=2'd2);
  - sb_entry_t struct {valid, rd};
  - REG_ZERO constant.
- One sub-module, load_scoreboard: shift register plus match logic, parameterised by LOAD_LATENCY. It exposes shift_en, push, push_rd, rs/rt/use inputs and a hit output.

Test Plan:
- LOAD_LATENCY=1. lw $5 in ID (issued), next cycle ID uses rs=5 → exactly one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; then RUN.
- lw $0 followed by a user of $0 → no stall (rd=0 never matches).
- LOAD_LATENCY=2. lw $7, independent instruction, then user of $7 → one bubble. Immediate user of $7 → two bubbles.
- Hazard and branch_taken in the same cycle → stall outputs only, if_id_flush=0. Next cycle (hazard cleared, branch_taken=1) → if_id_flush=1, pc_write=1.
- mem_stall=1 for 3 cycles during LOAD_STALL → all write enables 0 and scoreboard frozen. After release → remaining stall completes with the same bubble count.
- rst asserted during LOAD_STALL → next cycle after release: state=RUN, scoreboard empty, no stall on a matching rs.
